// File: rtl/dpram_access_arbiter.sv
// Two-requester front end for a dual-port RAM: same-address collisions stall the loser, reads return 1 cycle after accept.
// Backpressure: combinational ready per port; a per-port stall counter hands priority to a port starved for MAX_STALL cycles.
module dpram_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_STALL  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  localparam int SW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  logic [SW-1:0] stall_cnt_a, stall_cnt_b;
  logic          rvalid_a_q, rvalid_b_q;
  logic          a_sat, b_sat, collision, b_wins;
  logic          accept_a, accept_b;

  assign a_sat = (stall_cnt_a == STALL_MAX);
  assign b_sat = (stall_cnt_b == STALL_MAX);

  // Read/read on the same address is harmless; only a write on either side collides.
  assign collision = a_valid && b_valid && (a_addr == b_addr) && (a_we || b_we);

  always_comb begin
    b_wins = 1'b0;
    if (a_we) begin
      b_wins = b_sat && !a_sat;
    end else if (b_we) begin
      b_wins = !a_sat;
    end
  end

  assign a_ready  = rst_n && (!collision || !b_wins);
  assign b_ready  = rst_n && (!collision || b_wins);
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;

  assign ram_we_a   = accept_a && a_we;
  assign ram_addr_a = a_addr;
  assign ram_din_a  = a_wdata;
  assign ram_we_b   = accept_b && b_we;
  assign ram_addr_b = b_addr;
  assign ram_din_b  = b_wdata;

  // Gated so an outstanding read never shows while reset is held.
  assign a_rvalid = rvalid_a_q && rst_n;
  assign b_rvalid = rvalid_b_q && rst_n;
  assign a_rdata  = ram_dout_a;
  assign b_rdata  = ram_dout_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_a_q     <= 1'b0;
      rvalid_b_q     <= 1'b0;
      stall_cnt_a    <= '0;
      stall_cnt_b    <= '0;
      conflict_count <= '0;
    end else begin
      rvalid_a_q <= accept_a && !a_we;
      rvalid_b_q <= accept_b && !b_we;

      if (a_valid && !a_ready) begin
        if (!a_sat) stall_cnt_a <= stall_cnt_a + 1'b1;
      end else begin
        stall_cnt_a <= '0;
      end

      if (b_valid && !b_ready) begin
        if (!b_sat) stall_cnt_b <= stall_cnt_b + 1'b1;
      end else begin
        stall_cnt_b <= '0;
      end

      if (collision && (conflict_count != {CNT_WIDTH{1'b1}})) begin
        conflict_count <= conflict_count + 1'b1;
      end
    end
  end

endmodule
